// File: rtl/fir_inverse_if.sv
// Stream bundle for the inverse FIR: one input sample channel, one recovered-sample channel.
// A beat moves on a rising edge where valid && ready; a sender holds valid and its payload steady until that edge.
interface fir_inverse_if #(
   parameter int W_Y = 14,
   parameter int W_X = 8
);
   logic           s_valid;
   logic           s_ready;
   logic [W_Y-1:0] s_data;
   logic           m_valid;
   logic           m_ready;
   logic [W_X-1:0] m_data;
   logic           ovf;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, ovf
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, ovf
   );
endinterface

// File: rtl/fir_inverse.sv
// Sequential inverse (deconvolution) of a monic FIR: x[n] = y[n] - sum K[k]*x[n-k],
// one feedback tap per cycle through a single multiply-accumulate.
module fir_inverse #(
   parameter int N   = 5,
   parameter int W_X = 8,
   parameter int W_K = 3,
   parameter logic signed [W_K-1:0] K [N+1] = '{3'sd1, 3'sd2, 3'sd3, 3'sb100, 3'sd1, 3'sb110}
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   fir_inverse_if.slave bus,
   output logic [1:0]   state_dbg
);
   localparam int W_Y = W_X + W_K + $clog2(N);
   localparam int W_A = W_Y + W_K + $clog2(N) + 1;
   localparam int W_P = W_X + W_K;
   localparam int KW  = $clog2(N + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   localparam logic signed [W_A-1:0] X_MAX = W_A'((1 << (W_X - 1)) - 1);
   localparam logic signed [W_A-1:0] X_MIN = ~X_MAX;

   if (int'(K[0]) != 1) begin : g_k0_check
      $error("fir_inverse: K[0] must be 1");
   end
   if (N < 1) begin : g_n_check
      $error("fir_inverse: N must be at least 1");
   end

   logic [1:0]            state;
   logic [KW-1:0]         k;
   logic signed [W_X-1:0] hist [1:N];
   logic signed [W_A-1:0] acc;
   logic signed [W_P-1:0] prod;
   logic signed [W_X-1:0] sat_val;
   logic                  sat_ovf;
   logic                  m_valid_q;
   logic signed [W_X-1:0] m_data_q;
   logic                  ovf_q;

   always_comb begin
      prod = W_P'(K[k]) * W_P'(hist[k]);
   end

   // acc already holds the final sum while in OUT, so the clip is taken from it directly
   always_comb begin
      sat_val = acc[W_X-1:0];
      sat_ovf = 1'b0;
      if (acc > X_MAX) begin
         sat_val = X_MAX[W_X-1:0];
         sat_ovf = 1'b1;
      end else if (acc < X_MIN) begin
         sat_val = X_MIN[W_X-1:0];
         sat_ovf = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         k         <= KW'(1);
         acc       <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         ovf_q     <= 1'b0;
         for (int i = 1; i <= N; i++) hist[i] <= '0;
      end else if (clr) begin
         state     <= S_IDLE;
         k         <= KW'(1);
         acc       <= '0;
         m_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         for (int i = 1; i <= N; i++) hist[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.s_valid) begin
                  acc   <= W_A'($signed(bus.s_data));
                  k     <= KW'(1);
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc - W_A'(prod);
               if (k == KW'(N)) begin
                  state <= S_OUT;
               end else begin
                  k <= k + KW'(1);
               end
            end
            S_OUT: begin
               // first OUT cycle registers the clipped result; later cycles wait for the sink
               if (!m_valid_q) begin
                  m_valid_q <= 1'b1;
                  m_data_q  <= sat_val;
                  ovf_q     <= sat_ovf;
               end else if (bus.m_ready) begin
                  for (int i = N; i >= 2; i--) hist[i] <= hist[i-1];
                  hist[1]   <= m_data_q;
                  m_valid_q <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.s_ready = (state == S_IDLE);
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.ovf     = ovf_q;
   assign state_dbg   = state;
endmodule

// File: tb/tb_fir_inverse.sv
// Directed bench for fir_inverse: impulse, FIR round trip, backpressure, saturation,
// synchronous clear mid-MAC and asynchronous reset during OUT.
module tb_fir_inverse;
   localparam int N   = 5;
   localparam int W_X = 8;
   localparam int W_K = 3;
   localparam int W_Y = W_X + W_K + $clog2(N);
   localparam int KC [0:N] = '{1, 2, 3, -4, 1, -2};

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       clr = 1'b0;
   logic [1:0] state_dbg;

   int checks = 0;
   int failures = 0;
   logic [W_X-1:0] exp_q[$];

   fir_inverse_if #(.W_Y(W_Y), .W_X(W_X)) bus ();

   fir_inverse dut (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks; all leave the bench 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_accept(input int y);
      int n;
      n = 0;
      while (bus.s_ready !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (bus.s_ready !== 1'b1) begin
         failures++;
         $display("FAIL accept_wait: s_ready=%b required 1", bus.s_ready);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = W_Y'(y);
      tick();
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (bus.m_valid !== 1'b1 && lat < 30) begin
         tick();
         lat++;
      end
      checks++;
      if (bus.m_valid !== 1'b1) begin
         failures++;
         $display("FAIL out_wait: m_valid=%b required 1", bus.m_valid);
      end
   endtask

   task automatic take_out();
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      repeat (2) tick();
      checks++;
      if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready: got %b required 1", bus.s_ready); end
      checks++;
      if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b required 0", bus.m_valid); end
      checks++;
      if (bus.m_data !== 8'd0) begin failures++; $display("FAIL reset_m_data: got %0d required 0", $signed(bus.m_data)); end
      checks++;
      if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", bus.ovf); end
      checks++;
      if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_impulse(input string tag);
      int lat;
      do_accept(5);
      wait_out(lat);
      checks++;
      if (lat !== 6) begin failures++; $display("FAIL %s_latency: got %0d required 6", tag, lat); end
      checks++;
      if (bus.m_data !== 8'd5) begin failures++; $display("FAIL %s_data: got %0d required 5", tag, $signed(bus.m_data)); end
      checks++;
      if (bus.ovf !== 1'b0) begin failures++; $display("FAIL %s_ovf: got %b required 0", tag, bus.ovf); end
      checks++;
      if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL %s_s_ready_out: got %b required 0", tag, bus.s_ready); end
      take_out();
      checks++;
      if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_after_handshake: m_valid=%b s_ready=%b required 0 1", tag, bus.m_valid, bus.s_ready);
      end
   endtask

   task automatic test_round_trip();
      int ys [0:7] = '{1, 2, 3, -4, 1, -2, 0, 0};
      int xs [0:7] = '{1, 0, 0, 0, 0, 0, 0, 0};
      int xh [1:N];
      int lat, x, y;
      logic [W_X-1:0] e;
      pulse_clr();
      for (int i = 0; i < 8; i++) begin
         do_accept(ys[i]);
         wait_out(lat);
         checks++;
         if (bus.m_data !== W_X'(xs[i]) || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL round_trip_%0d: got %0d ovf=%b required %0d ovf=0", i, $signed(bus.m_data), bus.ovf, xs[i]);
         end
         take_out();
      end
      pulse_clr();
      for (int i = 1; i <= N; i++) xh[i] = 0;
      for (int i = 0; i < 12; i++) begin
         x = int'($urandom_range(0, 255)) - 128;
         y = x;
         for (int j = 1; j <= N; j++) y += KC[j] * xh[j];
         for (int j = N; j >= 2; j--) xh[j] = xh[j-1];
         xh[1] = x;
         exp_q.push_back(W_X'(x));
         do_accept(y);
         wait_out(lat);
         e = exp_q.pop_front();
         checks++;
         if (bus.m_data !== e || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL random_trip_%0d: got %0d ovf=%b required %0d ovf=0", i, $signed(bus.m_data), bus.ovf, $signed(e));
         end
         take_out();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      pulse_clr();
      do_accept(9);
      wait_out(lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== 8'd9 || bus.ovf !== 1'b0 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_cycle_%0d: m_valid=%b m_data=%0d ovf=%b s_ready=%b required 1 9 0 0",
                     i, bus.m_valid, $signed(bus.m_data), bus.ovf, bus.s_ready);
         end
         tick();
      end
      take_out();
      checks++;
      if (bus.s_ready !== 1'b1 || state_dbg !== 2'd0) begin
         failures++;
         $display("FAIL bp_release: s_ready=%b state=%0d required 1 0", bus.s_ready, state_dbg);
      end
      do_accept(18);
      checks++;
      if (state_dbg !== 2'd1) begin failures++; $display("FAIL bp_next_accept: state=%0d required 1", state_dbg); end
      wait_out(lat);
      checks++;
      if (lat !== 6) begin failures++; $display("FAIL bp_latency: got %0d required 6", lat); end
      checks++;
      if (bus.m_data !== 8'd0) begin failures++; $display("FAIL bp_history: got %0d required 0", $signed(bus.m_data)); end
      take_out();
   endtask

   task automatic test_saturation();
      int lat;
      int ys [0:2] = '{1000, 0, -2};
      int xs [0:2] = '{127, -128, -127};
      logic ov [0:2] = '{1'b1, 1'b1, 1'b0};
      pulse_clr();
      for (int i = 0; i < 3; i++) begin
         do_accept(ys[i]);
         wait_out(lat);
         checks++;
         if (bus.m_data !== W_X'(xs[i]) || bus.ovf !== ov[i]) begin
            failures++;
            $display("FAIL sat_%0d: got %0d ovf=%b required %0d ovf=%b", i, $signed(bus.m_data), bus.ovf, xs[i], ov[i]);
         end
         take_out();
      end
      pulse_clr();
      do_accept(-1000);
      wait_out(lat);
      checks++;
      if (bus.m_data !== 8'h80 || bus.ovf !== 1'b1) begin
         failures++;
         $display("FAIL sat_neg: got %0d ovf=%b required -128 ovf=1", $signed(bus.m_data), bus.ovf);
      end
      take_out();
   endtask

   task automatic test_clr_mid_mac();
      int lat;
      int seen;
      pulse_clr();
      do_accept(20);
      wait_out(lat);
      checks++;
      if (bus.m_data !== 8'd20) begin failures++; $display("FAIL clr_prefill: got %0d required 20", $signed(bus.m_data)); end
      take_out();
      do_accept(50);
      tick();
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (bus.s_ready !== 1'b1 || state_dbg !== 2'd0 || bus.m_valid !== 1'b0) begin
         failures++;
         $display("FAIL clr_abort: s_ready=%b state=%0d m_valid=%b required 1 0 0", bus.s_ready, state_dbg, bus.m_valid);
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.m_valid !== 1'b0) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL clr_no_output: got %0d valid cycles required 0", seen); end
      do_accept(7);
      wait_out(lat);
      checks++;
      if (bus.m_data !== 8'd7 || bus.ovf !== 1'b0) begin
         failures++;
         $display("FAIL clr_history: got %0d ovf=%b required 7 ovf=0", $signed(bus.m_data), bus.ovf);
      end
      take_out();
   endtask

   task automatic test_async_reset();
      int lat;
      pulse_clr();
      do_accept(1000);
      wait_out(lat);
      checks++;
      if (bus.m_data !== 8'd127 || bus.ovf !== 1'b1) begin
         failures++;
         $display("FAIL arst_pre: got %0d ovf=%b required 127 ovf=1", $signed(bus.m_data), bus.ovf);
      end
      #3;
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.m_valid !== 1'b0 || bus.m_data !== 8'd0 || bus.ovf !== 1'b0) begin
         failures++;
         $display("FAIL arst_immediate: m_valid=%b m_data=%0d ovf=%b required 0 0 0", bus.m_valid, $signed(bus.m_data), bus.ovf);
      end
      checks++;
      if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL arst_s_ready: got %b required 1", bus.s_ready); end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      tick();
      test_impulse("arst_impulse");
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      test_reset();
      test_impulse("impulse");
      test_round_trip();
      test_backpressure();
      test_saturation();
      test_clr_mid_mac();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
